// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave -- SPI mode 0 responder (CPOL=0, CPHA=0, MSB first).
//
// SCLK, CS and MOSI are oversampled in the i_clock domain. A 16-bit reply
// ({Tx_Upper_Byte, Tx_Lower_Byte}, latched when the frame starts) is shifted
// out on MISO. After the reply, FILL_BYTE repeats. Every 8 received MOSI bits
// are published on Rx_Recv_Byte together with a one-cycle byte_recv pulse.
//
// Parameters:
//   SYNC_STAGES   synchronizer depth on SCLK/CS/MOSI (2..3)
//   FILL_BYTE     byte sent on MISO once both reply bytes are exhausted
//
// Ports:
//   i_clock       system clock, rising edge
//   i_reset       synchronous active-high reset
//   enable        frames are accepted only while high (sampled in IDLE)
//   SCLK/CS/MOSI  asynchronous SPI inputs from the master (CS active low)
//   MISO          serial reply to the master
//   MISO_oe       output enable for MISO (only with SPI_SLAVE_TRISTATE_EN)
//   Tx_Upper_Byte first reply byte
//   Tx_Lower_Byte second reply byte
//   busy          high while an accepted frame is in progress
//   byte_recv     one-cycle pulse when Rx_Recv_Byte updates
//   Rx_Recv_Byte  last complete received byte
//   frame_done    one-cycle pulse when an accepted frame ends (CS rises)
//
// Optional feature macro: SPI_SLAVE_TRISTATE_EN
//   When defined, MISO_oe is added and MISO is driven high-Z outside frames.
// -----------------------------------------------------------------------------
module spi_slave #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       enable,
   input  logic       SCLK,
   input  logic       CS,
   input  logic       MOSI,
   output logic       MISO,
`ifdef SPI_SLAVE_TRISTATE_EN
   output logic       MISO_oe,
`endif
   input  logic [7:0] Tx_Upper_Byte,
   input  logic [7:0] Tx_Lower_Byte,
   output logic       busy,
   output logic       byte_recv,
   output logic [7:0] Rx_Recv_Byte,
   output logic       frame_done
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   localparam int unsigned LAST = SYNC_STAGES - 1;

   // Synchronizer chains, stage 0 samples the pin.
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   // Tracks which cs_sync stages hold a real pin sample rather than the reset
   // value; without it the reset value (1) would arm the block even if CS was
   // already low when reset released.
   logic [SYNC_STAGES-1:0] cs_valid_q,  cs_valid_d;

   logic        sclk_hist_q, sclk_hist_d;
   logic        cs_hist_q,   cs_hist_d;
   logic        armed_q,     armed_d;
   state_t      state_q,     state_d;
   logic [15:0] tx_shift_q,  tx_shift_d;
   logic [2:0]  tx_cnt_q,    tx_cnt_d;
   logic [7:0]  rx_shift_q,  rx_shift_d;
   logic [2:0]  bit_cnt_q,   bit_cnt_d;
   logic        miso_q,      miso_d;
   logic [7:0]  rx_byte_q,   rx_byte_d;
   logic        byte_recv_q, byte_recv_d;
   logic        frame_done_q, frame_done_d;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;

   // Synchronizer next-state: each stage takes the previous one.
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sclk_sync_d[gi] = SCLK;
            assign cs_sync_d[gi]   = CS;
            assign mosi_sync_d[gi] = MOSI;
            assign cs_valid_d[gi]  = 1'b1;
         end else begin : g_rest
            assign sclk_sync_d[gi] = sclk_sync_q[gi-1];
            assign cs_sync_d[gi]   = cs_sync_q[gi-1];
            assign mosi_sync_d[gi] = mosi_sync_q[gi-1];
            assign cs_valid_d[gi]  = cs_valid_q[gi-1];
         end
      end
   endgenerate

   assign sclk_s      = sclk_sync_q[LAST];
   assign cs_s        = cs_sync_q[LAST];
   assign mosi_s      = mosi_sync_q[LAST];
   assign sclk_hist_d = sclk_s;
   assign cs_hist_d   = cs_s;

   assign sclk_rise =  sclk_s & ~sclk_hist_q;
   assign sclk_fall = ~sclk_s &  sclk_hist_q;
   assign cs_fall   = ~cs_s   &  cs_hist_q;
   assign cs_rise   =  cs_s   & ~cs_hist_q;

   always_comb begin
      state_d      = state_q;
      tx_shift_d   = tx_shift_q;
      tx_cnt_d     = tx_cnt_q;
      rx_shift_d   = rx_shift_q;
      bit_cnt_d    = bit_cnt_q;
      miso_d       = miso_q;
      rx_byte_d    = rx_byte_q;
      byte_recv_d  = 1'b0;
      frame_done_d = 1'b0;
      armed_d      = armed_q | (cs_valid_q[LAST] & cs_s);

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall && armed_q && enable) begin
               state_d    = ACTIVE;
               tx_shift_d = {Tx_Upper_Byte, Tx_Lower_Byte};
               miso_d     = Tx_Upper_Byte[7];
               bit_cnt_d  = 3'd0;
               tx_cnt_d   = 3'd0;
            end
         end
         ACTIVE: begin
            // cs_rise wins over any SCLK edge seen in the same cycle.
            if (cs_rise) begin
               state_d      = IDLE;
               miso_d       = 1'b0;
               frame_done_d = 1'b1;
            end else if (sclk_rise) begin
               rx_shift_d = {rx_shift_q[6:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_byte_d   = {rx_shift_q[6:0], mosi_s};
                  byte_recv_d = 1'b1;
               end
            end else if (sclk_fall) begin
               // FILL_BYTE is fed in MSB first behind the reply, so after 16
               // shifts both halves hold FILL_BYTE and it repeats from then on.
               tx_shift_d = {tx_shift_q[14:0], FILL_BYTE[3'd7 - tx_cnt_q]};
               tx_cnt_d   = tx_cnt_q + 3'd1;
               miso_d     = tx_shift_q[14];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sclk_sync_q  <= '0;
         cs_sync_q    <= '1;
         mosi_sync_q  <= '1;
         cs_valid_q   <= '0;
         sclk_hist_q  <= 1'b0;
         cs_hist_q    <= 1'b1;
         armed_q      <= 1'b0;
         state_q      <= IDLE;
         tx_shift_q   <= '0;
         tx_cnt_q     <= '0;
         rx_shift_q   <= '0;
         bit_cnt_q    <= '0;
         miso_q       <= 1'b0;
         rx_byte_q    <= 8'h00;
         byte_recv_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         sclk_sync_q  <= sclk_sync_d;
         cs_sync_q    <= cs_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         cs_valid_q   <= cs_valid_d;
         sclk_hist_q  <= sclk_hist_d;
         cs_hist_q    <= cs_hist_d;
         armed_q      <= armed_d;
         state_q      <= state_d;
         tx_shift_q   <= tx_shift_d;
         tx_cnt_q     <= tx_cnt_d;
         rx_shift_q   <= rx_shift_d;
         bit_cnt_q    <= bit_cnt_d;
         miso_q       <= miso_d;
         rx_byte_q    <= rx_byte_d;
         byte_recv_q  <= byte_recv_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign busy         = (state_q == ACTIVE);
   assign byte_recv    = byte_recv_q;
   assign Rx_Recv_Byte = rx_byte_q;
   assign frame_done   = frame_done_q;

`ifdef SPI_SLAVE_TRISTATE_EN
   assign MISO_oe = (state_q == ACTIVE);
   assign MISO    = MISO_oe ? miso_q : 1'bz;
`else
   assign MISO = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave -- directed bench for spi_slave.
//
// A task plays the SPI master (mode 0, MSB first) and records the MISO bits it
// samples on each SCLK rise. Expected received bytes are queued by the test
// sequence; a monitor compares every byte_recv pulse against that queue and
// checks that Rx_Recv_Byte holds between pulses and that MISO is 0 whenever
// the block is not busy.
// -----------------------------------------------------------------------------
module tb_spi_slave;
   localparam int SYNC = 2;

   logic       i_clock = 1'b0;
   logic       i_reset, enable, SCLK, CS, MOSI;
   logic       MISO;
   logic [7:0] tx_u, tx_l;
   logic       busy, byte_recv, frame_done;
   logic [7:0] rx_byte;

   spi_slave #(.SYNC_STAGES(SYNC), .FILL_BYTE(8'h00)) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .enable        (enable),
      .SCLK          (SCLK),
      .CS            (CS),
      .MOSI          (MOSI),
      .MISO          (MISO),
      .Tx_Upper_Byte (tx_u),
      .Tx_Lower_Byte (tx_l),
      .busy          (busy),
      .byte_recv     (byte_recv),
      .Rx_Recv_Byte  (rx_byte),
      .frame_done    (frame_done)
   );

   always #5 i_clock = ~i_clock;

   int tests = 0;
   int fails = 0;

   // Model state
   logic [7:0] exp_rx[$];
   logic [7:0] model_last_rx = 8'h00;
   int         n_recv = 0, n_done = 0, n_busy = 0;
   bit         mon_en = 1'b0;

   logic [7:0] mosi_data [4];
   logic [7:0] miso_seen [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge i_clock);
      #1;
   endtask

   // Per-cycle monitor
   always @(negedge i_clock) begin
      if (mon_en) begin
         if (byte_recv) begin
            n_recv++;
            if (exp_rx.size() == 0) begin
               check("byte_recv_unexpected", {31'd0, byte_recv}, 32'd0);
            end else begin
               model_last_rx = exp_rx.pop_front();
               check("rx_byte", {24'd0, rx_byte}, {24'd0, model_last_rx});
            end
         end else begin
            check("rx_hold", {24'd0, rx_byte}, {24'd0, model_last_rx});
         end
         if (frame_done) n_done++;
         if (busy) n_busy++;
         else check("miso_idle", {31'd0, MISO}, 32'd0);
      end
   end

   // One SPI frame from the master's side. accept: frame is expected to be
   // taken. reset_bit: bit index at which i_reset pulses (-1 for none).
   // tx_swap: change Tx inputs shortly after the DUT has latched them.
   task automatic xfer(input int nbits, input int half, input bit accept,
                       input int reset_bit, input bit tx_swap);
      for (int i = 0; i < 4; i++) miso_seen[i] = 8'hxx;
      CS = 1'b0;
      for (int c = 0; c < half; c++) begin
         tick(1);
         if (tx_swap && c == SYNC) begin
            tx_u = 8'h11;
            tx_l = 8'h22;
         end
      end
      for (int b = 0; b < nbits; b++) begin
         MOSI = mosi_data[b/8][7-(b%8)];
         if (b == reset_bit) begin
            i_reset = 1'b1;
            tick(1);
            i_reset = 1'b0;
            model_last_rx = 8'h00;
            check("rst_busy",   {31'd0, busy}, 32'd0);
            check("rst_miso",   {31'd0, MISO}, 32'd0);
            check("rst_recv",   {31'd0, byte_recv}, 32'd0);
            check("rst_done",   {31'd0, frame_done}, 32'd0);
            check("rst_rxbyte", {24'd0, rx_byte}, 32'd0);
            tick(half - 1);
         end else begin
            tick(half);
         end
         if (accept) check("busy_in_frame", {31'd0, busy}, 32'd1);
         else if (b > reset_bit) check("busy_not_taken", {31'd0, busy}, 32'd0);
         miso_seen[b/8][7-(b%8)] = MISO;
         SCLK = 1'b1;
         tick(half);
         SCLK = 1'b0;
      end
      tick(half);
      CS = 1'b1;
      tick(half + SYNC + 2);
   endtask

   int r0, d0, b0;
   task automatic snap();
      r0 = n_recv; d0 = n_done; b0 = n_busy;
   endtask

   initial begin
      i_reset = 1'b1; enable = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
      tx_u = 8'hA5; tx_l = 8'h3C;
      tick(3);
      check("reset_miso",   {31'd0, MISO}, 32'd0);
      check("reset_busy",   {31'd0, busy}, 32'd0);
      check("reset_recv",   {31'd0, byte_recv}, 32'd0);
      check("reset_rxbyte", {24'd0, rx_byte}, 32'd0);
      check("reset_done",   {31'd0, frame_done}, 32'd0);
      i_reset = 1'b0;
      tick(6);
      mon_en = 1'b1;

      // Basic 2-byte frame
      mosi_data[0] = 8'hC3; mosi_data[1] = 8'h5A;
      exp_rx.push_back(8'hC3); exp_rx.push_back(8'h5A);
      snap();
      xfer(16, 6, 1'b1, -1, 1'b0);
      check("basic_miso0", {24'd0, miso_seen[0]}, 32'hA5);
      check("basic_miso1", {24'd0, miso_seen[1]}, 32'h3C);
      check("basic_recv",  n_recv - r0, 2);
      check("basic_done",  n_done - d0, 1);
      check("basic_qempty", exp_rx.size(), 0);

      // 4-byte frame, fill bytes after the reply
      mosi_data[0] = 8'h01; mosi_data[1] = 8'h02; mosi_data[2] = 8'h03; mosi_data[3] = 8'h04;
      for (int i = 0; i < 4; i++) exp_rx.push_back(mosi_data[i]);
      snap();
      xfer(32, 6, 1'b1, -1, 1'b0);
      check("four_miso0", {24'd0, miso_seen[0]}, 32'hA5);
      check("four_miso1", {24'd0, miso_seen[1]}, 32'h3C);
      check("four_miso2", {24'd0, miso_seen[2]}, 32'h00);
      check("four_miso3", {24'd0, miso_seen[3]}, 32'h00);
      check("four_recv",  n_recv - r0, 4);
      check("four_done",  n_done - d0, 1);
      check("four_qempty", exp_rx.size(), 0);

      // Aborted after 5 bits of the second byte
      mosi_data[0] = 8'h96; mosi_data[1] = 8'h7E;
      exp_rx.push_back(8'h96);
      snap();
      xfer(13, 6, 1'b1, -1, 1'b0);
      check("abort_miso0",  {24'd0, miso_seen[0]}, 32'hA5);
      check("abort_recv",   n_recv - r0, 1);
      check("abort_done",   n_done - d0, 1);
      check("abort_rxbyte", {24'd0, rx_byte}, 32'h96);
      check("abort_miso",   {31'd0, MISO}, 32'd0);
      check("abort_busy",   {31'd0, busy}, 32'd0);

      // enable low at frame start: frame ignored
      enable = 1'b0;
      mosi_data[0] = 8'h12; mosi_data[1] = 8'h34;
      snap();
      xfer(16, 6, 1'b0, -1, 1'b0);
      check("dis_recv",  n_recv - r0, 0);
      check("dis_done",  n_done - d0, 0);
      check("dis_busy",  n_busy - b0, 0);
      check("dis_miso0", {24'd0, miso_seen[0]}, 32'h00);
      check("dis_miso1", {24'd0, miso_seen[1]}, 32'h00);
      enable = 1'b1;
      mosi_data[0] = 8'hAB; mosi_data[1] = 8'hCD;
      exp_rx.push_back(8'hAB); exp_rx.push_back(8'hCD);
      snap();
      xfer(16, 6, 1'b1, -1, 1'b0);
      check("en_miso0", {24'd0, miso_seen[0]}, 32'hA5);
      check("en_miso1", {24'd0, miso_seen[1]}, 32'h3C);
      check("en_recv",  n_recv - r0, 2);
      check("en_done",  n_done - d0, 1);

      // Reset during bit 3 with CS held low: rest of frame ignored
      mosi_data[0] = 8'hF0; mosi_data[1] = 8'h0F;
      snap();
      xfer(16, 6, 1'b0, 3, 1'b0);
      check("rstf_recv",   n_recv - r0, 0);
      check("rstf_done",   n_done - d0, 0);
      check("rstf_rxbyte", {24'd0, rx_byte}, 32'h00);
      mosi_data[0] = 8'h5A; mosi_data[1] = 8'hA5;
      exp_rx.push_back(8'h5A); exp_rx.push_back(8'hA5);
      snap();
      xfer(16, 6, 1'b1, -1, 1'b0);
      check("rstn_miso0", {24'd0, miso_seen[0]}, 32'hA5);
      check("rstn_miso1", {24'd0, miso_seen[1]}, 32'h3C);
      check("rstn_recv",  n_recv - r0, 2);
      check("rstn_done",  n_done - d0, 1);

      // Minimum SCLK half-period, Tx changed right after the frame starts
      mosi_data[0] = 8'hC3; mosi_data[1] = 8'h5A;
      exp_rx.push_back(8'hC3); exp_rx.push_back(8'h5A);
      snap();
      xfer(16, SYNC + 2, 1'b1, -1, 1'b1);
      check("fast_miso0", {24'd0, miso_seen[0]}, 32'hA5);
      check("fast_miso1", {24'd0, miso_seen[1]}, 32'h3C);
      check("fast_recv",  n_recv - r0, 2);
      check("fast_done",  n_done - d0, 1);
      mosi_data[0] = 8'h00; mosi_data[1] = 8'hFF;
      exp_rx.push_back(8'h00); exp_rx.push_back(8'hFF);
      snap();
      xfer(16, SYNC + 2, 1'b1, -1, 1'b0);
      check("next_miso0", {24'd0, miso_seen[0]}, 32'h11);
      check("next_miso1", {24'd0, miso_seen[1]}, 32'h22);
      check("next_recv",  n_recv - r0, 2);
      check("final_qempty", exp_rx.size(), 0);

      tick(4);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
